// File: rtl/csi2_pkg.sv
// CSI-2 packet constants and frame sequencer state type.
// Shared by frame_sequencer and payload_counter.
package csi2_pkg;

    localparam logic [5:0] DT_FRAME_START = 6'h00;
    localparam logic [5:0] DT_FRAME_END   = 6'h01;
    localparam logic [5:0] DT_LONG_MIN    = 6'h10;

    // Payload bytes carried per image_data beat.
    localparam int unsigned BEAT_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        LINE
    } seq_state_t;

    function automatic logic is_long_packet(input logic [5:0] data_type);
        return data_type >= DT_LONG_MIN;
    endfunction

endpackage

// File: rtl/frame_sequencer_payload_counter.sv
// payload_counter: tracks the payload bytes left in the current long packet.
// Ports:
//   clock, reset   rising-edge clock, synchronous active-high reset
//   load           capture load_count as the new remaining byte count
//   load_count     long packet word_count
//   consume        one beat accepted; remaining drops by min(4, remaining)
//   byte_enable    per-byte validity of the beat taken at the current count
//   last_beat      current beat finishes the payload (remaining <= 4)
module payload_counter
    import csi2_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_count,
    input  logic        consume,
    output logic [3:0]  byte_enable,
    output logic        last_beat
);

    logic [15:0] remaining;
    logic [15:0] beat_bytes;

    always_comb begin
        beat_bytes = (remaining >= 16'(BEAT_BYTES)) ? 16'(BEAT_BYTES) : remaining;
        last_beat  = remaining <= 16'(BEAT_BYTES);
        case (remaining)
            16'd0:   byte_enable = 4'b0000;
            16'd1:   byte_enable = 4'b0001;
            16'd2:   byte_enable = 4'b0011;
            16'd3:   byte_enable = 4'b0111;
            default: byte_enable = 4'b1111;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            remaining <= '0;
        end else if (load) begin
            remaining <= load_count;
        end else if (consume) begin
            remaining <= remaining - beat_bytes;
        end
    end

endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: follows CSI-2 frame/line structure on one virtual channel
// and turns accepted payload beats into registered pixel words.
// Ports:
//   clock, reset                  rising-edge clock, synchronous active-high reset
//   header_valid, virtual_channel,
//   data_type, word_count         decoded packet header (one-cycle pulse)
//   image_data, image_data_enable payload beat, element 0 earliest byte
//   frame_valid, line_valid       in-frame / in-line status
//   frame_number                  data field of last accepted Frame Start
//   pixel_word, pixel_byte_enable,
//   pixel_valid                   registered accepted beat
//   line_done                     pulse on the final beat of a line
//   line_count, lines_last_frame  saturating line counters
//   protocol_error                sticky until reset
module frame_sequencer
    import csi2_pkg::*;
#(
    parameter logic [1:0] VIRTUAL_CHANNEL  = 2'd0,
    parameter int         LINE_COUNT_WIDTH = 12
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        header_valid,
    input  logic [1:0]                  virtual_channel,
    input  logic [5:0]                  data_type,
    input  logic [15:0]                 word_count,
    input  logic [3:0][7:0]             image_data,
    input  logic                        image_data_enable,
    output logic                        frame_valid,
    output logic                        line_valid,
    output logic [15:0]                 frame_number,
    output logic [3:0][7:0]             pixel_word,
    output logic [3:0]                  pixel_byte_enable,
    output logic                        pixel_valid,
    output logic                        line_done,
    output logic [LINE_COUNT_WIDTH-1:0] line_count,
    output logic [LINE_COUNT_WIDTH-1:0] lines_last_frame,
    output logic                        protocol_error
);

    seq_state_t state, state_next;

    logic       header_hit;
    logic       error_now;
    logic       load_payload;
    logic       beat_accept;
    logic       line_done_next;
    logic       count_clear;
    logic       count_inc;
    logic       latch_last;
    logic       frame_start;
    logic [3:0] byte_enable;
    logic       last_beat;

    payload_counter u_payload_counter (
        .clock       (clock),
        .reset       (reset),
        .load        (load_payload),
        .load_count  (word_count),
        .consume     (beat_accept),
        .byte_enable (byte_enable),
        .last_beat   (last_beat)
    );

    always_comb begin
        state_next     = state;
        load_payload   = 1'b0;
        beat_accept    = 1'b0;
        line_done_next = 1'b0;
        count_clear    = 1'b0;
        count_inc      = 1'b0;
        latch_last     = 1'b0;
        frame_start    = 1'b0;

        header_hit = header_valid && (virtual_channel == VIRTUAL_CHANNEL);
        // A beat is only legal in LINE with no header competing for the cycle.
        error_now  = image_data_enable && (header_hit || state != LINE);

        case (state)
            IDLE: begin
                if (header_hit) begin
                    if (data_type == DT_FRAME_START) begin
                        state_next  = FRAME;
                        frame_start = 1'b1;
                        count_clear = 1'b1;
                    end else if (data_type == DT_FRAME_END || is_long_packet(data_type)) begin
                        error_now = 1'b1;
                    end
                end
            end
            FRAME: begin
                if (header_hit) begin
                    if (data_type == DT_FRAME_START) begin
                        error_now = 1'b1;
                    end else if (data_type == DT_FRAME_END) begin
                        state_next = IDLE;
                        latch_last = 1'b1;
                    end else if (is_long_packet(data_type)) begin
                        if (word_count == '0) begin
                            line_done_next = 1'b1;
                            count_inc      = 1'b1;
                        end else begin
                            state_next   = LINE;
                            load_payload = 1'b1;
                        end
                    end
                end
            end
            LINE: begin
                if (header_hit) begin
                    // Any header aborts the line; a Frame End also closes the frame.
                    error_now = 1'b1;
                    if (data_type == DT_FRAME_END) begin
                        state_next = IDLE;
                        latch_last = 1'b1;
                    end else begin
                        state_next = FRAME;
                    end
                end else if (image_data_enable) begin
                    beat_accept = 1'b1;
                    if (last_beat) begin
                        line_done_next = 1'b1;
                        count_inc      = 1'b1;
                        state_next     = FRAME;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state             <= IDLE;
            frame_valid       <= 1'b0;
            line_valid        <= 1'b0;
            frame_number      <= '0;
            pixel_word        <= '0;
            pixel_byte_enable <= '0;
            pixel_valid       <= 1'b0;
            line_done         <= 1'b0;
            line_count        <= '0;
            lines_last_frame  <= '0;
            protocol_error    <= 1'b0;
        end else begin
            state       <= state_next;
            frame_valid <= state_next != IDLE;
            line_valid  <= state_next == LINE;
            pixel_valid <= beat_accept;
            line_done   <= line_done_next;
            if (beat_accept) begin
                pixel_word        <= image_data;
                pixel_byte_enable <= byte_enable;
            end
            if (frame_start) begin
                frame_number <= word_count;
            end
            if (count_clear) begin
                line_count <= '0;
            end else if (count_inc && line_count != '1) begin
                line_count <= line_count + 1'b1;
            end
            if (latch_last) begin
                lines_last_frame <= line_count;
            end
            if (error_now) begin
                protocol_error <= 1'b1;
            end
        end
    end

endmodule
